decompressor_sequencer: RTL and testbench

Controller that drives decompressor_top from a packed compressed stream. Each group in the stream is one control word followed by up to 8 items. The block unpacks the control-word bits one per item and issues each item to the decompressor using its busy handshake. It counts the decompressed bytes and reports done or error. It sits between the input stream source (memory reader or host FIFO) and decompressor_top.

---
 rtl/decompressor_pkg.sv | 18 +
 rtl/decompressor_sequencer_cw_unpacker.sv | 52 +++++
 rtl/decompressor_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_decompressor_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decompressor_pkg.sv
// Shared types and defaults for the decompressor stream sequencer.
package decompressor_pkg;

    localparam int GROUP_SIZE_DEF = 8;
    localparam int COUNT_W_DEF    = 16;
    localparam int GRP_IDX_W      = $clog2(GROUP_SIZE_DEF) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_CW    = 3'd1,
        GET_ITEM  = 3'd2,
        ISSUE     = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5,
        FINISH    = 3'd6
    } seq_state_t;

endpackage

// File: rtl/decompressor_sequencer_cw_unpacker.sv
// Control-word unpacker: holds the current group's control bits and the
// index of the item in flight; bits are consumed LSB first.
module cw_unpacker
    import decompressor_pkg::*;
#(
    parameter int GROUP_SIZE = GROUP_SIZE_DEF,
    parameter int IDX_W      = $clog2(GROUP_SIZE) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [GROUP_SIZE-1:0] cw_i,
    output logic                  bit_o,
    output logic                  group_end_o
);

    logic [GROUP_SIZE-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Load restarts the group; advance retires the item in flight.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load_i) begin
            shift_d = cw_i;
            idx_d   = '0;
        end else if (advance_i) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
        end else begin
            shift_d = shift_q;
            idx_d   = idx_q;
        end
    end

    // Shift register and group index state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign bit_o       = shift_q[0];
    // High while the last item of the group is in flight.
    assign group_end_o = (idx_q == IDX_W'(GROUP_SIZE - 1));

endmodule

// File: rtl/decompressor_sequencer.sv
// Feeds decompressor_top from a packed control-word/item stream and counts output bytes.
// Optional busy-stall watchdog enabled by defining DECOMP_SEQ_WATCHDOG_EN.
module decompressor_sequencer
    import decompressor_pkg::*;
#(
    parameter int GROUP_SIZE  = GROUP_SIZE_DEF,
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] item_count,
    input  logic [15:0]        in_word,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [15:0]        dec_data_in,
    output logic               dec_control_word_in,
    output logic               dec_data_in_valid,
    input  logic               dec_busy,
    input  logic               dec_out_valid,
    output logic [COUNT_W-1:0] bytes_out,
    output logic               busy,
    output logic               done,
    output logic               error
);

    seq_state_t         state_q, state_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [COUNT_W-1:0] bytes_q, bytes_d;
    logic [15:0]        data_q, data_d;
    logic               ctrl_q, ctrl_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               fin_idle_q, fin_idle_d;
    logic               in_ready_q, busy_q;
    logic               accept_s, cw_load_s, cw_adv_s, cw_bit_s, group_end_s;

`ifdef DECOMP_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               error_q, error_d;
`endif

    assign accept_s = in_valid && in_ready_q;

    cw_unpacker #(
        .GROUP_SIZE (GROUP_SIZE)
    ) u_cw_unpacker (
        .clk_i       (clock),
        .rst_i       (reset),
        .load_i      (cw_load_s),
        .advance_i   (cw_adv_s),
        .cw_i        (in_word[GROUP_SIZE-1:0]),
        .bit_o       (cw_bit_s),
        .group_end_o (group_end_s)
    );

    // Sequencer next-state, issue and byte-count logic.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        fin_idle_d = 1'b0;
        cw_load_s  = 1'b0;
        cw_adv_s   = 1'b0;
        if (busy_q && dec_out_valid && (bytes_q != {COUNT_W{1'b1}})) begin
            bytes_d = bytes_q + COUNT_W'(1);
        end else begin
            bytes_d = bytes_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bytes_d = '0;
                    if (item_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = item_count;
                        state_d = GET_CW;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GET_CW: begin
                if (accept_s) begin
                    cw_load_s = 1'b1;
                    state_d   = GET_ITEM;
                end else begin
                    state_d = GET_CW;
                end
            end
            GET_ITEM: begin
                if (accept_s) begin
                    data_d  = in_word;
                    ctrl_d  = cw_bit_s;
                    state_d = ISSUE;
                end else begin
                    state_d = GET_ITEM;
                end
            end
            ISSUE: begin
                if (!dec_busy) begin
                    valid_d = 1'b1;
                    state_d = WAIT_ACK;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_ACK: begin
                if (dec_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!dec_busy) begin
                    rem_d    = rem_q - COUNT_W'(1);
                    cw_adv_s = 1'b1;
                    if (rem_q == COUNT_W'(1)) begin
                        state_d = FINISH;
                    end else if (group_end_s) begin
                        state_d = GET_CW;
                    end else begin
                        state_d = GET_ITEM;
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            FINISH: begin
                // One extra idle cycle lets the trailing out_valid land in bytes_out.
                if (!dec_busy) begin
                    if (fin_idle_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fin_idle_d = 1'b1;
                    end
                end else begin
                    fin_idle_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DECOMP_SEQ_WATCHDOG_EN
        error_d = (state_q == IDLE && start) ? 1'b0 : error_q;
        if ((state_q == WAIT_ACK || state_q == WAIT_DONE) && (state_d == state_q)) begin
            if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                wdog_d  = '0;
                error_d = 1'b1;
                valid_d = 1'b0;
                data_d  = '0;
                ctrl_d  = 1'b0;
                state_d = IDLE;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end else begin
            wdog_d = '0;
        end
`endif
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            bytes_q    <= '0;
            data_q     <= '0;
            ctrl_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            fin_idle_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            bytes_q    <= bytes_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            fin_idle_q <= fin_idle_d;
            in_ready_q <= (state_d == GET_CW) || (state_d == GET_ITEM);
            busy_q     <= (state_d != IDLE);
        end
    end

`ifdef DECOMP_SEQ_WATCHDOG_EN
    // Stall counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready            = in_ready_q;
    assign dec_data_in         = data_q;
    assign dec_control_word_in = ctrl_q;
    assign dec_data_in_valid   = valid_q;
    assign bytes_out           = bytes_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_decompressor_sequencer.sv
// Randomized self-checking bench for decompressor_sequencer with a behavioural decompressor model.
module tb_decompressor_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] item_count = 16'd0;
    logic [15:0] in_word = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dec_data_in;
    logic        dec_control_word_in;
    logic        dec_data_in_valid;
    logic        dec_busy = 1'b0;
    logic        dec_out_valid = 1'b0;
    logic [15:0] bytes_out;
    logic        busy;
    logic        done;
    logic        error;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [15:0] stream_q[$];
    logic [15:0] acc_log[$];
    logic [15:0] got_data[$];
    logic        got_ctrl[$];
    logic [15:0] job_data[$];
    logic [15:0] job_cw[$];

    int   model_len = 0;
    int   model_out = -1;
    int   model_bytes = 0;
    int   m_len, m_out;
    int   viol = 0;
    logic prev_valid = 1'b0;
    logic pend_acc = 1'b0;
    bit   done_seen, err_seen;
    int   extra_done;
    logic [15:0] bytes_at_done;

    decompressor_sequencer #(
        .GROUP_SIZE  (8),
        .COUNT_W     (16),
        .WDOG_CYCLES (16)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .item_count          (item_count),
        .in_word             (in_word),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .dec_data_in         (dec_data_in),
        .dec_control_word_in (dec_control_word_in),
        .dec_data_in_valid   (dec_data_in_valid),
        .dec_busy            (dec_busy),
        .dec_out_valid       (dec_out_valid),
        .bytes_out           (bytes_out),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clock = ~clock;

    // Decompressor model: busy the cycle after sampling valid, out_valid pulses while busy.
    always begin
        @(negedge clock);
        if (dec_data_in_valid) begin
            got_data.push_back(dec_data_in);
            got_ctrl.push_back(dec_control_word_in);
            m_len = (model_len > 0) ? model_len : int'($urandom_range(1, 5));
            m_out = (model_out >= 0) ? model_out : int'($urandom_range(0, m_len));
            @(posedge clock);
            #1;
            dec_busy = 1'b1;
            for (int i = 0; i < m_len; i++) begin
                dec_out_valid = (i < m_out);
                if (i < m_out) model_bytes++;
                @(posedge clock);
                #1;
            end
            dec_out_valid = 1'b0;
            dec_busy = 1'b0;
        end
    end

    // Stream source with random gaps; a word is taken when presented while in_ready is high.
    always @(negedge clock) begin
        if (pend_acc) begin
            acc_log.push_back(in_word);
            if (stream_q.size() > 0) void'(stream_q.pop_front());
        end
        if (stream_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_word  = stream_q[0];
        end else begin
            in_valid = 1'b0;
            in_word  = 16'($urandom);
        end
        pend_acc = in_valid && in_ready && !reset;
    end

    // Protocol monitor: no stream accept while decompressor busy, valid is a single-cycle pulse.
    always @(negedge clock) begin
        if (in_ready && dec_busy) viol++;
        if (dec_data_in_valid && prev_valid) viol++;
        prev_valid = dec_data_in_valid;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic logic [37:0] all_out();
        return {in_ready, dec_data_in, dec_control_word_in, dec_data_in_valid, bytes_out, busy, done, error};
    endfunction

    function automatic logic exp_bit(int i);
        logic [15:0] w;
        w = job_cw[i / 8];
        return w[i % 8];
    endfunction

    task automatic make_job(int n);
        job_data.delete();
        job_cw.delete();
        for (int i = 0; i < n; i++) job_data.push_back(16'($urandom));
        for (int g = 0; g < (n + 7) / 8; g++) job_cw.push_back(16'($urandom));
    endtask

    task automatic start_job(int n);
        stream_q.delete();
        acc_log.delete();
        got_data.delete();
        got_ctrl.delete();
        model_bytes = 0;
        viol = 0;
        for (int i = 0; i < n; i++) begin
            if (i % 8 == 0) stream_q.push_back(job_cw[i / 8]);
            stream_q.push_back(job_data[i]);
        end
        stream_q.push_back(16'hDEAD);
        stream_q.push_back(16'hBEEF);
        @(negedge clock);
        start = 1'b1;
        item_count = 16'(n);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        done_seen = 1'b0;
        err_seen = 1'b0;
        extra_done = 0;
        for (int i = 0; i < budget && !done_seen; i++) begin
            @(negedge clock);
            if (error) err_seen = 1'b1;
            if (done) begin
                done_seen = 1'b1;
                bytes_at_done = bytes_out;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done) extra_done++;
        end
    endtask

    task automatic wait_model_idle();
        for (int i = 0; i < 200 && dec_busy; i++) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        chk_cnt++; if (all_out() !== 38'd0) $display("FAIL reset_outputs: got %h want 0", all_out()); else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk_cnt++; if (all_out() !== 38'd0) $display("FAIL idle_outputs: got %h want 0", all_out()); else pass_cnt++;
    endtask

    task automatic test_basic();
        job_cw.delete(); job_data.delete();
        job_cw.push_back(16'h0005);
        job_data.push_back(16'h0041); job_data.push_back(16'h1234); job_data.push_back(16'h0042);
        model_len = 3; model_out = 1;
        start_job(3);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else pass_cnt++;
        wait_done(300);
        chk_cnt++; if (!done_seen) $display("FAIL basic_done: got 0 want 1"); else pass_cnt++;
        chk_cnt++; if (extra_done != 0) $display("FAIL basic_single_done: got %0d extra want 0", extra_done); else pass_cnt++;
        chk_cnt++; if (got_data.size() != 3) $display("FAIL basic_issue_count: got %0d want 3", got_data.size()); else pass_cnt++;
        if (got_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk_cnt++; if (got_data[i] !== job_data[i] || got_ctrl[i] !== exp_bit(i))
                    $display("FAIL basic_item%0d: got %h/%b want %h/%b", i, got_data[i], got_ctrl[i], job_data[i], exp_bit(i));
                else pass_cnt++;
            end
        end
        chk_cnt++; if (acc_log.size() != 4) $display("FAIL basic_words: got %0d want 4", acc_log.size()); else pass_cnt++;
        chk_cnt++; if (viol != 0) $display("FAIL basic_protocol: got %0d violations want 0", viol); else pass_cnt++;
        chk_cnt++; if (bytes_at_done !== 16'd3) $display("FAIL basic_bytes: got %0d want 3", bytes_at_done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_two_groups();
        make_job(10);
        job_cw[0] = 16'h00FF;
        job_cw[1] = 16'h0003;
        model_len = 0; model_out = -1;
        start_job(10);
        wait_done(600);
        chk_cnt++; if (!done_seen) $display("FAIL groups_done: got 0 want 1"); else pass_cnt++;
        chk_cnt++; if (acc_log.size() != 12) $display("FAIL groups_words: got %0d want 12", acc_log.size()); else pass_cnt++;
        if (acc_log.size() >= 10) begin
            chk_cnt++; if (acc_log[9] !== 16'h0003) $display("FAIL groups_cw2_index: got %h want 0003", acc_log[9]); else pass_cnt++;
        end
        chk_cnt++; if (got_data.size() != 10) $display("FAIL groups_issue_count: got %0d want 10", got_data.size()); else pass_cnt++;
        if (got_data.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk_cnt++; if (got_data[i] !== job_data[i] || got_ctrl[i] !== exp_bit(i))
                    $display("FAIL groups_item%0d: got %h/%b want %h/%b", i, got_data[i], got_ctrl[i], job_data[i], exp_bit(i));
                else pass_cnt++;
            end
        end
        chk_cnt++; if (bytes_at_done !== 16'(model_bytes)) $display("FAIL groups_bytes: got %0d want %0d", bytes_at_done, model_bytes); else pass_cnt++;
        chk_cnt++; if (viol != 0) $display("FAIL groups_protocol: got %0d want 0", viol); else pass_cnt++;
    endtask

    task automatic test_zero();
        job_cw.delete(); job_data.delete();
        start_job(0);
        chk_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0 || bytes_out !== 16'd0) $display("FAIL zero_idle: got rdy=%b bytes=%0d want 0/0", in_ready, bytes_out); else pass_cnt++;
        @(negedge clock);
        chk_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_pulse: got done=%b busy=%b want 0/0", done, busy); else pass_cnt++;
        // A stray decompressor busy in idle must not wake the sequencer.
        dec_busy = 1'b1;
        @(negedge clock);
        dec_busy = 1'b0;
        repeat (3) @(negedge clock);
        chk_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0 || acc_log.size() != 0)
            $display("FAIL zero_busy_pulse: got busy=%b rdy=%b words=%0d want 0/0/0", busy, in_ready, acc_log.size());
        else pass_cnt++;
    endtask

    task automatic test_bytes();
        make_job(4);
        model_len = 6; model_out = 5;
        start_job(4);
        wait_done(400);
        chk_cnt++; if (!done_seen) $display("FAIL bytes_done: got 0 want 1"); else pass_cnt++;
        chk_cnt++; if (bytes_at_done !== 16'd20) $display("FAIL bytes_count: got %0d want 20", bytes_at_done); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int k;
        make_job(4);
        model_len = 8; model_out = 2;
        start_job(4);
        k = 0;
        while (k < 400 && !(got_data.size() >= 2 && dec_busy)) begin
            @(negedge clock);
            k++;
        end
        chk_cnt++; if (k >= 400) $display("FAIL rmid_reach: got timeout want item2 busy"); else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_cnt++; if (all_out() !== 38'd0) $display("FAIL rmid_outputs: got %h want 0", all_out()); else pass_cnt++;
        reset = 1'b0;
        wait_model_idle();
        stream_q.delete();
        repeat (3) @(negedge clock);
        chk_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_abort: got done=%b busy=%b want 0/0", done, busy); else pass_cnt++;
        make_job(5);
        model_len = 0; model_out = -1;
        start_job(5);
        wait_done(400);
        chk_cnt++; if (!done_seen || got_data.size() != 5) $display("FAIL rmid_rerun: got done=%b items=%0d want 1/5", done_seen, got_data.size()); else pass_cnt++;
        if (got_data.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk_cnt++; if (got_data[i] !== job_data[i] || got_ctrl[i] !== exp_bit(i))
                    $display("FAIL rmid_item%0d: got %h/%b want %h/%b", i, got_data[i], got_ctrl[i], job_data[i], exp_bit(i));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_watchdog();
        make_job(1);
        model_len = 40; model_out = 0;
`ifdef DECOMP_SEQ_WATCHDOG_EN
        begin
            int k, n, dcnt;
            start_job(1);
            k = 0;
            while (k < 100 && !dec_busy) begin @(negedge clock); k++; end
            n = 0; dcnt = 0;
            while (n < 60 && !error) begin
                @(negedge clock);
                n++;
                if (done) dcnt++;
            end
            chk_cnt++; if (error !== 1'b1) $display("FAIL wdog_error: got %b want 1", error); else pass_cnt++;
            chk_cnt++; if (n != 17) $display("FAIL wdog_timing: got %0d cycles want 17", n); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b0 || dec_data_in_valid !== 1'b0) $display("FAIL wdog_idle: got busy=%b valid=%b want 0/0", busy, dec_data_in_valid); else pass_cnt++;
            wait_model_idle();
            repeat (2) @(negedge clock);
            if (done) dcnt++;
            chk_cnt++; if (dcnt != 0 || error !== 1'b1) $display("FAIL wdog_nodone: got dones=%0d err=%b want 0/1", dcnt, error); else pass_cnt++;
            model_len = 2;
            start_job(1);
            chk_cnt++; if (error !== 1'b0) $display("FAIL wdog_clear: got %b want 0", error); else pass_cnt++;
            wait_done(200);
            chk_cnt++; if (!done_seen) $display("FAIL wdog_recover: got 0 want 1"); else pass_cnt++;
        end
`else
        start_job(1);
        wait_done(300);
        chk_cnt++; if (!done_seen) $display("FAIL nowdog_done: got 0 want 1"); else pass_cnt++;
        chk_cnt++; if (err_seen || error !== 1'b0) $display("FAIL nowdog_error: got %b want 0", err_seen); else pass_cnt++;
`endif
        model_len = 0; model_out = -1;
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            int n;
            n = int'($urandom_range(1, 20));
            make_job(n);
            start_job(n);
            if (j == 0) begin
                // Start while busy must be ignored.
                repeat (6) @(negedge clock);
                start = 1'b1; item_count = 16'd2;
                @(negedge clock);
                start = 1'b0;
            end
            wait_done(2000);
            chk_cnt++; if (!done_seen || extra_done != 0) $display("FAIL b2b%0d_done: got %b/%0d want 1/0", j, done_seen, extra_done); else pass_cnt++;
            chk_cnt++; if (got_data.size() != n) $display("FAIL b2b%0d_count: got %0d want %0d", j, got_data.size(), n); else pass_cnt++;
            if (got_data.size() == n) begin
                for (int i = 0; i < n; i++) begin
                    chk_cnt++; if (got_data[i] !== job_data[i] || got_ctrl[i] !== exp_bit(i))
                        $display("FAIL b2b%0d_item%0d: got %h/%b want %h/%b", j, i, got_data[i], got_ctrl[i], job_data[i], exp_bit(i));
                    else pass_cnt++;
                end
            end
            chk_cnt++; if (acc_log.size() != n + (n + 7) / 8) $display("FAIL b2b%0d_words: got %0d want %0d", j, acc_log.size(), n + (n + 7) / 8); else pass_cnt++;
            chk_cnt++; if (bytes_at_done !== 16'(model_bytes)) $display("FAIL b2b%0d_bytes: got %0d want %0d", j, bytes_at_done, model_bytes); else pass_cnt++;
            chk_cnt++; if (viol != 0) $display("FAIL b2b%0d_protocol: got %0d want 0", j, viol); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_groups();
        test_zero();
        test_bytes();
        test_reset_mid();
        test_watchdog();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
